// File: rtl/dmem_port_pkg.sv
// Shared types and helpers for the data-memory port.
//   dmem_state_t    : port FSM states (IDLE, BUSY, DONE)
//   load_funct3_t   : RV32I load width/sign encodings
//   store_funct3_t  : RV32I store width encodings
//   is_misaligned() : alignment check for a request's funct3 and byte offset
package dmem_port_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Unlisted funct3 codes behave as full-word accesses, so they need
  // word alignment.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic res;
    res = 1'b0;
    if (is_store) begin
      case (funct3)
        SB:      res = 1'b0;
        SH:      res = off[0];
        default: res = (off != 2'b00);
      endcase
    end else begin
      case (funct3)
        LB, LBU: res = 1'b0;
        LH, LHU: res = off[0];
        default: res = (off != 2'b00);
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Data-cache bus between the MEM-stage port (master) and the cache (slave).
//   mem_addr  : word-aligned byte address
//   mem_read  : read strobe, held until mem_resp
//   mem_write : write strobe, held until mem_resp
//   mem_wmask : byte-lane write enables
//   mem_wdata : lane-shifted store data
//   mem_rdata : cache read data, valid with mem_resp
//   mem_resp  : single-cycle completion
interface dmem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_read;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_wmask;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_resp;

  modport master (
    output mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/dmem_load_align.sv
// Combinational load alignment: picks the addressed byte/half/word out of
// the cache word and sign- or zero-extends it.
//   funct3    : load encoding (load_funct3_t)
//   offset    : byte offset within the word (addr[1:0])
//   mem_rdata : raw cache word
//   rdata     : aligned, extended result
module dmem_load_align
  import dmem_port_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = mem_rdata[{offset, 3'b000} +: 8];
    half_s = mem_rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      LB:      rdata = {{(DATA_W-8){byte_s[7]}}, byte_s};
      LBU:     rdata = {{(DATA_W-8){1'b0}}, byte_s};
      LH:      rdata = {{(DATA_W-16){half_s[15]}}, half_s};
      LHU:     rdata = {{(DATA_W-16){1'b0}}, half_s};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// MEM-stage data-memory port. Accepts a load/store request from the
// pipeline, runs one handshaked transaction on the cache bus, stalls the
// pipeline until the cache responds, then holds the result until the
// pipeline advances.
//   clk, rst       : clock, synchronous active-high reset
//   req_read/write : MEM-stage load/store request (both high = store)
//   req_funct3     : load/store width encoding
//   req_addr       : byte address
//   req_wdata      : LSB-justified store data
//   pipe_advance   : pipeline consumes the result this cycle
//   stall          : hold upstream stages
//   rdata          : aligned/extended load result
//   rdata_valid    : rdata meaningful (loads in DONE)
//   misaligned     : one-cycle pulse on a rejected misaligned request
//   mem            : cache bus (master side)
module dmem_port
  import dmem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              pipe_advance,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  dmem_port_if.master       mem
);

  function automatic logic [LANES-1:0] store_mask(input logic [2:0] f3,
                                                  input logic [1:0] off);
    logic [LANES-1:0] m;
    case (f3)
      SB:      m = LANES'(1) << off;
      SH:      m = off[1] ? 4'b1100 : 4'b0011;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [2:0]        f3,
                                                   input logic [1:0]        off,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    case (f3)
      SB:      d = DATA_W'(wd[7:0]) << {off, 3'b000};
      SH:      d = DATA_W'(wd[15:0]) << {off[1], 4'b0000};
      default: d = wd;
    endcase
    return d;
  endfunction

  dmem_state_t state, next_state;

  logic              req_any;
  logic              req_bad;
  logic              req_go;
  logic [DATA_W-1:0] aligned;

  logic [ADDR_W-1:0] mem_addr_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic [LANES-1:0]  mem_wmask_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic [2:0]        ld_funct3_p1;
  logic [1:0]        ld_off_p1;
  logic [DATA_W-1:0] rdata_p2;
  logic              vld_p2;

  // A simultaneous read+write is a store; the read is dropped.
  assign req_any = req_read | req_write;
  assign req_bad = req_any && is_misaligned(req_write, req_funct3, req_addr[1:0]);
  assign req_go  = (state == IDLE) && req_any && !req_bad && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (req_go) begin
          stall      = 1'b1;
          next_state = BUSY;
        end else if (req_bad && !rst) begin
          misaligned = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_resp) next_state = DONE;
      end
      DONE: begin
        if (pipe_advance) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
    .funct3    (ld_funct3_p1),
    .offset    (ld_off_p1),
    .mem_rdata (mem.mem_rdata),
    .rdata     (aligned)
  );

  // Stage p1: request latched onto the cache bus
  // Stage p2: response captured into rdata
  // rdata is cleared on leaving DONE so it reads 0 whenever the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_p1  <= '0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      mem_wmask_p1 <= '0;
      mem_wdata_p1 <= '0;
      ld_funct3_p1 <= '0;
      ld_off_p1    <= '0;
      rdata_p2     <= '0;
      vld_p2       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_go) begin
            mem_addr_p1  <= {req_addr[ADDR_W-1:2], 2'b00};
            ld_funct3_p1 <= req_funct3;
            ld_off_p1    <= req_addr[1:0];
            mem_read_p1  <= !req_write;
            mem_write_p1 <= req_write;
            mem_wmask_p1 <= req_write ? store_mask(req_funct3, req_addr[1:0]) : '0;
            mem_wdata_p1 <= req_write ? store_data(req_funct3, req_addr[1:0], req_wdata) : '0;
          end
        end
        BUSY: begin
          if (mem.mem_resp) begin
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            rdata_p2     <= mem_read_p1 ? aligned : '0;
            vld_p2       <= mem_read_p1;
          end
        end
        DONE: begin
          if (pipe_advance) begin
            rdata_p2 <= '0;
            vld_p2   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_addr  = mem_addr_p1;
  assign mem.mem_read  = mem_read_p1;
  assign mem.mem_write = mem_write_p1;
  assign mem.mem_wmask = mem_wmask_p1;
  assign mem.mem_wdata = mem_wdata_p1;
  assign rdata         = rdata_p2;
  assign rdata_valid   = vld_p2;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed steps followed by random
// load/store transactions, compared against an arithmetic reference model.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write, pipe_advance;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, misaligned;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_rdata, last_wmask, last_wdata, last_addr;

  dmem_port_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  dmem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .pipe_advance (pipe_advance),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .misaligned   (misaligned),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned o, b, h;
    o = a % 4;
    b = (rd >> (8 * o)) % 256;
    h = (rd >> (16 * (o / 2))) % 65536;
    case (f3)
      0:       return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      4:       return 32'(b);
      1:       return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      5:       return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_mask(input int f3, input logic [31:0] a);
    int unsigned o;
    o = a % 4;
    if (f3 == 0) return 32'(1 << o);
    if (f3 == 1) return 32'(3 << (2 * (o / 2)));
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned o;
    o = a % 4;
    if (f3 == 0) return (wd % 256) << (8 * o);
    if (f3 == 1) return (wd % 65536) << (16 * (o / 2));
    return wd;
  endfunction

  function automatic logic ref_mis(input logic st, input int f3, input logic [31:0] a);
    if (st) begin
      if (f3 == 0) return 1'b0;
      if (f3 == 1) return (a % 2) != 0;
      return (a % 4) != 0;
    end
    if (f3 == 0 || f3 == 4) return 1'b0;
    if (f3 == 1 || f3 == 5) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic idle_req();
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  // Called at posedge+1. Returns at posedge+2 with the port back in IDLE.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int dly, input int hold);
    logic        st;
    logic [31:0] exp_r;
    st = wr;
    req_read = rd; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    if (ref_mis(st, int'(f3), a)) begin
      check("mis_pulse", {31'd0, misaligned}, 32'd1);
      check("mis_stall", {31'd0, stall}, 32'd0);
      check("mis_rdata", rdata, 32'd0);
      check("mis_rvalid", {31'd0, rdata_valid}, 32'd0);
      @(posedge clk); #1; idle_req(); #1;
      check("mis_no_read", {31'd0, mif.mem_read}, 32'd0);
      check("mis_no_write", {31'd0, mif.mem_write}, 32'd0);
      check("mis_drop", {31'd0, misaligned}, 32'd0);
      return;
    end
    check("acc_stall", {31'd0, stall}, 32'd1);
    check("acc_mis", {31'd0, misaligned}, 32'd0);
    @(posedge clk); #1; idle_req(); #1;
    check("strobe_read", {31'd0, mif.mem_read}, {31'd0, !st});
    check("strobe_write", {31'd0, mif.mem_write}, {31'd0, st});
    check("mem_addr", mif.mem_addr, a & 32'hFFFF_FFFC);
    last_addr = mif.mem_addr;
    if (st) begin
      check("wmask", {28'd0, mif.mem_wmask}, ref_mask(int'(f3), a));
      check("wdata", mif.mem_wdata, ref_wdata(int'(f3), a, wd));
      last_wmask = {28'd0, mif.mem_wmask};
      last_wdata = mif.mem_wdata;
    end
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      check("busy_stall", {31'd0, stall}, 32'd1);
      check("busy_strobe", {31'd0, mif.mem_read | mif.mem_write}, 32'd1);
      check("busy_addr", mif.mem_addr, a & 32'hFFFF_FFFC);
    end
    mif.mem_resp = 1'b1; mif.mem_rdata = rdat; #1;
    check("resp_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    mif.mem_resp = 1'b0; mif.mem_rdata = $urandom; #1;
    exp_r = st ? 32'd0 : ref_load(int'(f3), a, rdat);
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_strobes", {30'd0, mif.mem_read, mif.mem_write}, 32'd0);
    check("done_rvalid", {31'd0, rdata_valid}, {31'd0, !st});
    if (!st) check("done_rdata", rdata, exp_r);
    last_rdata = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      mif.mem_resp = 1'($urandom_range(0, 1)); mif.mem_rdata = $urandom; #1;
      if (!st) check("hold_rdata", rdata, exp_r);
      check("hold_rvalid", {31'd0, rdata_valid}, {31'd0, !st});
      check("hold_strobes", {30'd0, mif.mem_read, mif.mem_write}, 32'd0);
      check("hold_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    mif.mem_resp = 1'b0; pipe_advance = 1'b1;
    @(posedge clk); #1;
    pipe_advance = 1'b0; #1;
    check("adv_rvalid", {31'd0, rdata_valid}, 32'd0);
    check("adv_stall", {31'd0, stall}, 32'd0);
    check("adv_strobes", {30'd0, mif.mem_read, mif.mem_write}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; pipe_advance = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    mif.mem_resp = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    check("rst_strobes", {30'd0, mif.mem_read, mif.mem_write}, 32'd0);
    check("rst_addr", mif.mem_addr, 32'd0);
    check("rst_wmask", {28'd0, mif.mem_wmask}, 32'd0);
    check("rst_wdata", mif.mem_wdata, 32'd0);

    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
    check("lw_rdata", last_rdata, 32'hDEADBEEF);
    check("lw_addr", last_addr, 32'h100);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
    check("lb_rdata", last_rdata, 32'hFFFFFF80);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 0);
    check("lbu_rdata", last_rdata, 32'h00000080);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 2, 0);
    check("lhu_rdata", last_rdata, 32'h000080FF);
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 3'b000, 32'h102, 32'h123456AB, 32'h0, 1, 0);
    check("sb_addr", last_addr, 32'h100);
    check("sb_wmask", last_wmask, 32'h4);
    check("sb_wdata", last_wdata, 32'h00AB0000);
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 3'b001, 32'h101, 32'hCAFE, 32'h0, 0, 0);
    @(posedge clk); #1;
    check("post_mis_stall", {31'd0, stall}, 32'd0);
    check("post_mis_write", {31'd0, mif.mem_write}, 32'd0);

    // Reset while BUSY, then a stale response.
    req_read = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge clk); #1; idle_req(); #1;
    check("rb_read", {31'd0, mif.mem_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    check("rb_read_drop", {31'd0, mif.mem_read}, 32'd0);
    check("rb_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mif.mem_resp = 1'b1; mif.mem_rdata = 32'h11223344;
    @(posedge clk); #1; mif.mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rb_rvalid", {31'd0, rdata_valid}, 32'd0);
      check("rb_idle_stall", {31'd0, stall}, 32'd0);
      check("rb_idle_read", {31'd0, mif.mem_read}, 32'd0);
    end

    // DONE held four cycles, then a fresh transaction.
    run_txn(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 32'h8001_7FFF, 0, 4);
    check("hold_lh_rdata", last_rdata, 32'hFFFF8001);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 3'b010, 32'h404, 32'h5A5A_A5A5, 32'hFFFF_FFFF, 1, 1);
    check("rw_store_wdata", last_wdata, 32'h5A5A_A5A5);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      run_txn(kind != 2'd1, kind != 2'd0 && kind != 2'd3, 3'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
